mac_acc_frame: RTL

- Parametrised, pipelined multiply-accumulate unit that accumulates over framed sample streams.
- Each frame is delimited by first/last markers; one result is emitted per frame.
- Compared with the earlier fixed-function MAC it adds:
  - configurable signed/unsigned arithmetic
  - a configurable multiplier pipeline depth
  - saturating or wrapping accumulation
  - a sticky overflow flag
- Sits between the sample-pairing front end and the result collector in the MAC datapath study.

---
 rtl/mac_pkg.sv | 37 +++
 rtl/mac_acc_frame_mul.sv | 66 ++++++
 rtl/mac_acc_frame.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants and helpers for the framed MAC: product width, saturation
// bounds and the parameter legality test applied at elaboration.
package mac_pkg;

    localparam int MAX_W = 128;

    function automatic int prod_width(input int in_w);
        return 2 * in_w;
    endfunction

    // Largest representable accumulator value, returned in MAX_W-bit two's complement.
    function automatic logic [MAX_W-1:0] sat_max(input int width, input bit is_signed);
        logic [MAX_W-1:0] one_s;
        one_s = {{(MAX_W-1){1'b0}}, 1'b1};
        if (is_signed) begin
            return (one_s << (width - 1)) - one_s;
        end else begin
            return (one_s << width) - one_s;
        end
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int width, input bit is_signed);
        logic [MAX_W-1:0] one_s;
        one_s = {{(MAX_W-1){1'b0}}, 1'b1};
        if (is_signed) begin
            return ~(one_s << (width - 1)) + one_s;
        end else begin
            return {MAX_W{1'b0}};
        end
    endfunction

    function automatic bit params_legal(input int in_w, input int out_w, input int stages);
        return (in_w >= 2) && (out_w >= 2 * in_w + 1) && (out_w < MAX_W) &&
               (stages >= 1) && (stages <= 3);
    endfunction

endpackage

// File: rtl/mac_acc_frame_mul.sv
// Multiplier pipeline: full-precision product plus valid/first/last sideband,
// delayed by MUL_STAGES registers.
module mac_mul_pipe
    import mac_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int SIGNED      = 1,
    parameter int MUL_STAGES  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [INPUT_WIDTH-1:0]        a_i,
    input  logic [INPUT_WIDTH-1:0]        b_i,
    input  logic                          valid_i,
    input  logic                          first_i,
    input  logic                          last_i,
    output logic [2*INPUT_WIDTH-1:0]      prod_o,
    output logic                          valid_o,
    output logic                          first_o,
    output logic                          last_o
);

    localparam int PW = prod_width(INPUT_WIDTH);

    logic [PW-1:0] a_ext_s;
    logic [PW-1:0] b_ext_s;
    logic [PW-1:0] prod_d;
    logic [PW-1:0] prod_q [MUL_STAGES];
    logic [2:0]    side_q [MUL_STAGES];

    // Operand extension and multiply; the low PW bits of the product of
    // sign-extended operands are the exact signed product.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext_s = {{INPUT_WIDTH{a_i[INPUT_WIDTH-1]}}, a_i};
            b_ext_s = {{INPUT_WIDTH{b_i[INPUT_WIDTH-1]}}, b_i};
        end else begin
            a_ext_s = {{INPUT_WIDTH{1'b0}}, a_i};
            b_ext_s = {{INPUT_WIDTH{1'b0}}, b_i};
        end
        prod_d = a_ext_s * b_ext_s;
    end

    // Product and sideband shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i] <= {PW{1'b0}};
                side_q[i] <= 3'b000;
            end
        end else begin
            prod_q[0] <= prod_d;
            side_q[0] <= {valid_i, first_i, last_i};
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                side_q[i] <= side_q[i-1];
            end
        end
    end

    assign prod_o  = prod_q[MUL_STAGES-1];
    assign valid_o = side_q[MUL_STAGES-1][2];
    assign first_o = side_q[MUL_STAGES-1][1];
    assign last_o  = side_q[MUL_STAGES-1][0];

endmodule

// File: rtl/mac_acc_frame.sv
// Framed multiply-accumulate: input registers, multiplier pipeline, saturating
// or wrapping accumulator with a per-frame sticky overflow, registered results.
module mac_acc_frame
    import mac_pkg::*;
#(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 40,
    parameter int SIGNED       = 1,
    parameter int SATURATE     = 1,
    parameter int MUL_STAGES   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INPUT_WIDTH-1:0]  input_a,
    input  logic [INPUT_WIDTH-1:0]  input_b,
    input  logic                    input_valid,
    input  logic                    input_first,
    input  logic                    input_last,
    output logic [OUTPUT_WIDTH-1:0] output_val,
    output logic                    output_valid,
    output logic                    output_overflow
);

    localparam int PW = prod_width(INPUT_WIDTH);
    localparam int EW = OUTPUT_WIDTH + 1;
    localparam logic [MAX_W-1:0] SAT_MAX_FULL = sat_max(OUTPUT_WIDTH, SIGNED != 0);
    localparam logic [MAX_W-1:0] SAT_MIN_FULL = sat_min(OUTPUT_WIDTH, SIGNED != 0);
    localparam logic [OUTPUT_WIDTH-1:0] SAT_MAX = SAT_MAX_FULL[OUTPUT_WIDTH-1:0];
    localparam logic [OUTPUT_WIDTH-1:0] SAT_MIN = SAT_MIN_FULL[OUTPUT_WIDTH-1:0];

    if (!params_legal(INPUT_WIDTH, OUTPUT_WIDTH, MUL_STAGES)) begin : g_bad_params
        $error("mac_acc_frame: illegal INPUT_WIDTH/OUTPUT_WIDTH/MUL_STAGES combination");
    end

    logic [INPUT_WIDTH-1:0]  a_q;
    logic [INPUT_WIDTH-1:0]  b_q;
    logic                    valid_q;
    logic                    first_q;
    logic                    last_q;

    logic [PW-1:0]           mul_prod_s;
    logic                    mul_valid_s;
    logic                    mul_first_s;
    logic                    mul_last_s;

    logic [OUTPUT_WIDTH-1:0] base_s;
    logic [EW-1:0]           base_ext_s;
    logic [EW-1:0]           prod_ext_s;
    logic [EW-1:0]           sum_s;
    logic                    ovf_hi_s;
    logic                    ovf_lo_s;

    logic [OUTPUT_WIDTH-1:0] acc_q, acc_d;
    logic                    sticky_q, sticky_d;
    logic [OUTPUT_WIDTH-1:0] out_val_q, out_val_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_ovf_q, out_ovf_d;

    // Input stage: operands and frame flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= {INPUT_WIDTH{1'b0}};
            b_q     <= {INPUT_WIDTH{1'b0}};
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            a_q     <= input_a;
            b_q     <= input_b;
            valid_q <= input_valid;
            first_q <= input_first & input_valid;
            last_q  <= input_last & input_valid;
        end
    end

    mac_mul_pipe #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .SIGNED      (SIGNED),
        .MUL_STAGES  (MUL_STAGES)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_i     (a_q),
        .b_i     (b_q),
        .valid_i (valid_q),
        .first_i (first_q),
        .last_i  (last_q),
        .prod_o  (mul_prod_s),
        .valid_o (mul_valid_s),
        .first_o (mul_first_s),
        .last_o  (mul_last_s)
    );

    // One extra bit of headroom lets overflow be read from the top two sum bits.
    always_comb begin
        if (mul_first_s) begin
            base_s = {OUTPUT_WIDTH{1'b0}};
        end else begin
            base_s = acc_q;
        end

        if (SIGNED != 0) begin
            base_ext_s = {base_s[OUTPUT_WIDTH-1], base_s};
            prod_ext_s = {{(EW-PW){mul_prod_s[PW-1]}}, mul_prod_s};
        end else begin
            base_ext_s = {1'b0, base_s};
            prod_ext_s = {{(EW-PW){1'b0}}, mul_prod_s};
        end

        sum_s = base_ext_s + prod_ext_s;

        if (SIGNED != 0) begin
            ovf_hi_s = ~sum_s[EW-1] & sum_s[EW-2];
            ovf_lo_s = sum_s[EW-1] & ~sum_s[EW-2];
        end else begin
            ovf_hi_s = sum_s[EW-1];
            ovf_lo_s = 1'b0;
        end

        if (!mul_valid_s) begin
            acc_d = acc_q;
        end else if (ovf_hi_s && (SATURATE != 0)) begin
            acc_d = SAT_MAX;
        end else if (ovf_lo_s && (SATURATE != 0)) begin
            acc_d = SAT_MIN;
        end else begin
            acc_d = sum_s[OUTPUT_WIDTH-1:0];
        end

        if (!mul_valid_s) begin
            sticky_d = sticky_q;
        end else if (mul_first_s) begin
            sticky_d = ovf_hi_s | ovf_lo_s;
        end else begin
            sticky_d = sticky_q | ovf_hi_s | ovf_lo_s;
        end

        out_valid_d = mul_valid_s & mul_last_s;
        if (out_valid_d) begin
            out_val_d = acc_d;
            out_ovf_d = sticky_d;
        end else begin
            out_val_d = out_val_q;
            out_ovf_d = out_ovf_q;
        end
    end

    // Accumulator, sticky flag and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= {OUTPUT_WIDTH{1'b0}};
            sticky_q    <= 1'b0;
            out_val_q   <= {OUTPUT_WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_val_q   <= out_val_d;
            out_valid_q <= out_valid_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign output_val      = out_val_q;
    assign output_valid    = out_valid_q;
    assign output_overflow = out_ovf_q;

endmodule
